// File: rtl/scan_pkg.sv
// Purpose: shared 7-segment patterns and digit helpers for the scan counter display.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Contents: seg_t, SEG_0..SEG_F / SEG_BLANK (active-low {g..a}), bcd_clamp(), seg_decode().
package scan_pkg;

   typedef logic [6:0] seg_t;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam seg_t SEG_0     = 7'h40;
   localparam seg_t SEG_1     = 7'h79;
   localparam seg_t SEG_2     = 7'h24;
   localparam seg_t SEG_3     = 7'h30;
   localparam seg_t SEG_4     = 7'h19;
   localparam seg_t SEG_5     = 7'h12;
   localparam seg_t SEG_6     = 7'h02;
   localparam seg_t SEG_7     = 7'h78;
   localparam seg_t SEG_8     = 7'h00;
   localparam seg_t SEG_9     = 7'h10;
   localparam seg_t SEG_A     = 7'h08;
   localparam seg_t SEG_B     = 7'h03;
   localparam seg_t SEG_C     = 7'h46;
   localparam seg_t SEG_D     = 7'h21;
   localparam seg_t SEG_E     = 7'h06;
   localparam seg_t SEG_F     = 7'h0E;
   localparam seg_t SEG_BLANK = 7'h7F;

   // Digits above 9 saturate to 9 so a BCD counter never holds an illegal digit
   function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   function automatic seg_t seg_decode(input logic [3:0] d);
      seg_t s;
      case (d)
         4'h0:    s = SEG_0;
         4'h1:    s = SEG_1;
         4'h2:    s = SEG_2;
         4'h3:    s = SEG_3;
         4'h4:    s = SEG_4;
         4'h5:    s = SEG_5;
         4'h6:    s = SEG_6;
         4'h7:    s = SEG_7;
         4'h8:    s = SEG_8;
         4'h9:    s = SEG_9;
         4'hA:    s = SEG_A;
         4'hB:    s = SEG_B;
         4'hC:    s = SEG_C;
         4'hD:    s = SEG_D;
         4'hE:    s = SEG_E;
         4'hF:    s = SEG_F;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/db_edge.sv
// Purpose: 2-flop synchroniser, stable-time debouncer and rising-edge pulse for a raw button.
// Latency: rise pulses DB_CYC+2 clk after the raw input settles high; pulse is 1 clk wide.
// Backpressure: none; pulses are fire-and-forget.
// Ports: clk, rst_n (async active-low), btn (raw, asynchronous), rise (1-clk pulse).
module db_edge #(
   parameter int DB_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic rise
);

   localparam int DW = (DB_CYC > 1) ? $clog2(DB_CYC + 1) : 1;

   logic [1:0]    sync;
   logic          level;
   logic [DW-1:0] stable_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync       <= 2'b00;
         level      <= 1'b0;
         stable_cnt <= '0;
         rise       <= 1'b0;
      end else begin
         sync <= {sync[0], btn};
         rise <= 1'b0;
         if (sync[1] == level) begin
            // Any glitch back to the current level restarts the stable-time count
            stable_cnt <= '0;
         end else if (stable_cnt == DW'(DB_CYC - 1)) begin
            // DB_CYC consecutive samples disagreed with level: accept the new level
            level      <= sync[1];
            rise       <= sync[1];
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + DW'(1);
         end
      end
   end

endmodule

// File: rtl/scan_counter_display.sv
// Purpose: multi-digit BCD/hex up/down counter driving a multiplexed active-low 7-segment display.
// Latency: count/load/clear registered 1 clk after the tick or debounced pulse; seg/scan update together.
// Backpressure: none; enable=0 freezes the count while ticks and scanning keep running.
// Ports: clk, clr (async active-low), enable, load/dir_btn/zero (raw buttons), data -> q, up, tc, seg, scan.
module scan_counter_display
   import scan_pkg::*;
#(
   parameter int CLK_HZ   = 100_000_000,
   parameter int COUNT_HZ = 1,
   parameter int SCAN_HZ  = 1_000,
   parameter int DIGITS   = 4,
   parameter int BCD      = 1,
   parameter int DB_CYC   = 1_000_000
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                enable,
   input  logic                load,
   input  logic                dir_btn,
   input  logic                zero,
   input  logic [4*DIGITS-1:0] data,
   output logic [4*DIGITS-1:0] q,
   output logic                up,
   output logic                tc,
   output seg_t                seg,
   output logic [DIGITS-1:0]   scan
);

   localparam int CNT_DIV  = CLK_HZ / COUNT_HZ;
   localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int CW       = (CNT_DIV  > 1) ? $clog2(CNT_DIV)  : 1;
   localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW       = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;
   localparam logic [3:0] DMAX = (BCD != 0) ? 4'd9 : 4'd15;

   if (CNT_DIV < 2)  begin : g_bad_cnt_div  $error("CLK_HZ/COUNT_HZ must be >= 2"); end
   if (SCAN_DIV < 2) begin : g_bad_scan_div $error("CLK_HZ/SCAN_HZ must be >= 2");  end
   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits $error("DIGITS must be 1..8"); end

   // ---------------- clock-enable tick dividers ----------------
   logic [CW-1:0] cnt_div;
   logic [SW-1:0] scan_div;
   logic          cnt_tick, scan_tick;

   assign cnt_tick  = (cnt_div  == CW'(CNT_DIV - 1));
   assign scan_tick = (scan_div == SW'(SCAN_DIV - 1));

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt_div  <= '0;
         scan_div <= '0;
      end else begin
         cnt_div  <= cnt_tick  ? '0 : cnt_div  + CW'(1);
         scan_div <= scan_tick ? '0 : scan_div + SW'(1);
      end
   end

   // ---------------- button conditioning ----------------
   logic ld_p, dir_p, zero_p;

   db_edge #(.DB_CYC(DB_CYC)) u_db_load (.clk(clk), .rst_n(clr), .btn(load),    .rise(ld_p));
   db_edge #(.DB_CYC(DB_CYC)) u_db_dir  (.clk(clk), .rst_n(clr), .btn(dir_btn), .rise(dir_p));
   db_edge #(.DB_CYC(DB_CYC)) u_db_zero (.clk(clk), .rst_n(clr), .btn(zero),    .rise(zero_p));

   // ---------------- digit chain ----------------
   // chain[i] = digit i must step (carry in when up, borrow in when down);
   // chain[DIGITS] set means every digit wrapped, i.e. terminal count.
   logic [4*DIGITS-1:0] step_q, ld_q, q_nxt;
   logic [DIGITS:0]     chain;
   logic                tc_nxt;

   assign chain[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [3:0] d;
      logic       at_lim;
      assign d               = q[4*i +: 4];
      assign at_lim          = up ? (d == DMAX) : (d == 4'd0);
      assign chain[i+1]      = chain[i] & at_lim;
      assign step_q[4*i +: 4] = !chain[i] ? d :
                                at_lim   ? (up ? 4'd0 : DMAX) :
                                           (up ? d + 4'd1 : d - 4'd1);
      assign ld_q[4*i +: 4]   = (BCD != 0) ? bcd_clamp(data[4*i +: 4]) : data[4*i +: 4];
   end

   always_comb begin
      q_nxt  = q;
      tc_nxt = 1'b0;
      if (zero_p) begin
         q_nxt = '0;
      end else if (ld_p) begin
         q_nxt = ld_q;
      end else if (cnt_tick && enable) begin
         q_nxt  = step_q;
         tc_nxt = chain[DIGITS];
      end
   end

   // ---------------- scan index ----------------
   logic [IW-1:0] idx, idx_nxt;

   always_comb begin
      idx_nxt = idx;
      if (scan_tick) idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
   end

   // seg is decoded from the next count and next index so the pattern and the
   // digit enable change on the same edge and never show a neighbour's digit.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         q   <= '0;
         up  <= 1'b1;
         tc  <= 1'b0;
         idx <= '0;
         seg <= SEG_0;
      end else begin
         q   <= q_nxt;
         up  <= up ^ dir_p;   // step above used the old direction this clk
         tc  <= tc_nxt;
         idx <= idx_nxt;
         seg <= seg_decode(q_nxt[4*idx_nxt +: 4]);
      end
   end

   assign scan = ~(DIGITS'(1) << idx);

endmodule

// File: tb/tb_scan_counter_display.sv
module tb_scan_counter_display;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic        dir_btn = 1'b0;
   logic        zero = 1'b0;
   logic [15:0] data = 16'h0000;

   logic [15:0] q_b, q_h;
   logic        up_b, up_h, tc_b, tc_h;
   logic [6:0]  seg_b, seg_h;
   logic [3:0]  scan_b, scan_h;

   int n_chk = 0;
   int n_fail = 0;
   int cyc;
   int tcb_cnt = 0;
   int tch_cnt = 0;

   typedef struct {
      logic [15:0] data;
      logic [15:0] q_bcd;
      logic [15:0] q_hex;
   } ld_vec_t;

   ld_vec_t vecs[6];

   scan_counter_display #(
      .CLK_HZ(1000), .COUNT_HZ(100), .SCAN_HZ(250), .DIGITS(4), .BCD(1), .DB_CYC(4)
   ) u_bcd (
      .clk(clk), .clr(clr), .enable(enable), .load(load), .dir_btn(dir_btn), .zero(zero),
      .data(data), .q(q_b), .up(up_b), .tc(tc_b), .seg(seg_b), .scan(scan_b)
   );

   scan_counter_display #(
      .CLK_HZ(1000), .COUNT_HZ(100), .SCAN_HZ(250), .DIGITS(4), .BCD(0), .DB_CYC(4)
   ) u_hex (
      .clk(clk), .clr(clr), .enable(enable), .load(load), .dir_btn(dir_btn), .zero(zero),
      .data(data), .q(q_h), .up(up_h), .tc(tc_h), .seg(seg_h), .scan(scan_h)
   );

   always #5 clk = ~clk;

   // Edge count since reset release; the count tick fires on edges where cyc%10==0
   always @(posedge clk or negedge clr) begin
      if (!clr) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (tc_b) tcb_cnt++;
      if (tc_h) tch_cnt++;
   end

   function automatic logic [6:0] seg_ref(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
         12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr = 1'b0;
      wait_clk(2);
      clr = 1'b1;
   endtask

   // which: 0 = load, 1 = dir_btn, 2 = zero
   task automatic press(input int which);
      if (which == 0) load = 1'b1; else if (which == 1) dir_btn = 1'b1; else zero = 1'b1;
      wait_clk(10);
      load = 1'b0; dir_btn = 1'b0; zero = 1'b0;
      wait_clk(10);
   endtask

   // Park on a negedge where the next load edge, pressed now, lands on a count tick
   task automatic align_to_tick(input string name);
      bit found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (cyc % 10 == 3) found = 1'b1;
      end
      check({name, "_align"}, 32'(found), 32'd1);
   endtask

   initial begin
      int idx;
      int dig0;

      vecs[0] = '{16'h1A3F, 16'h1939, 16'h1A3F};
      vecs[1] = '{16'hFFFF, 16'h9999, 16'hFFFF};
      vecs[2] = '{16'h5A0C, 16'h5909, 16'h5A0C};
      vecs[3] = '{16'h0000, 16'h0000, 16'h0000};
      vecs[4] = '{16'h9B7E, 16'h9979, 16'h9B7E};
      vecs[5] = '{16'h1234, 16'h1234, 16'h1234};

      // ---- 1: reset state, then free-running count and scan ----
      enable = 1'b1;
      do_reset();
      check("rst_q",    32'(q_b),    32'h0);
      check("rst_up",   32'(up_b),   32'h1);
      check("rst_tc",   32'(tc_b),   32'h0);
      check("rst_scan", 32'(scan_b), 32'b1110);
      check("rst_seg",  32'(seg_b),  32'h40);
      for (int n = 1; n <= 25; n++) begin
         @(negedge clk);
         idx  = (n / 4) % 4;
         dig0 = n / 10;
         check($sformatf("run_q_%0d", n),    32'(q_b),    32'(dig0));
         check($sformatf("run_scan_%0d", n), 32'(scan_b), 32'(~(4'b0001 << idx) & 4'hF));
         check($sformatf("run_seg_%0d", n),  32'(seg_b),  32'(seg_ref(idx == 0 ? dig0 : 0)));
      end
      check("t1_q25_bcd", 32'(q_b), 32'h0002);
      check("t1_q25_hex", 32'(q_h), 32'h0002);

      // ---- 2: BCD wrap 9998 -> 9999 -> 0000 with one tc pulse ----
      enable = 1'b0;
      do_reset();
      data = 16'h9998;
      press(0);
      check("t2_load", 32'(q_b), 32'h9998);
      tcb_cnt = 0; tch_cnt = 0;
      enable = 1'b1;
      wait_clk(20);
      enable = 1'b0;
      wait_clk(2);
      check("t2_q_bcd",  32'(q_b),  32'h0000);
      check("t2_tc_bcd", 32'(tcb_cnt), 32'd1);
      check("t2_q_hex",  32'(q_h),  32'h999A);
      check("t2_tc_hex", 32'(tch_cnt), 32'd0);

      // ---- 3: direction toggle then down-step from zero ----
      do_reset();
      press(1);
      check("t3_up_bcd", 32'(up_b), 32'h0);
      check("t3_up_hex", 32'(up_h), 32'h0);
      tcb_cnt = 0; tch_cnt = 0;
      enable = 1'b1;
      wait_clk(10);
      enable = 1'b0;
      wait_clk(2);
      check("t3_q_hex",  32'(q_h),     32'hFFFF);
      check("t3_tc_hex", 32'(tch_cnt), 32'd1);
      check("t3_q_bcd",  32'(q_b),     32'h9999);
      check("t3_tc_bcd", 32'(tcb_cnt), 32'd1);
      check("t3_up_hold", 32'(up_h),   32'h0);

      // ---- 4: load table with BCD clamping, then a bouncing load ----
      do_reset();
      for (int v = 0; v < 6; v++) begin
         data = vecs[v].data;
         press(0);
         check($sformatf("ld_bcd_%0d", v), 32'(q_b), 32'(vecs[v].q_bcd));
         check($sformatf("ld_hex_%0d", v), 32'(q_h), 32'(vecs[v].q_hex));
         check($sformatf("ld_tc_%0d", v),  32'(tc_b), 32'h0);
      end
      data = 16'h5555;
      for (int i = 0; i < 10; i++) begin
         load = 1'b1; wait_clk(2);
         load = 1'b0; wait_clk(2);
      end
      wait_clk(10);
      check("t4_bounce_bcd", 32'(q_b), 32'h1234);
      check("t4_bounce_hex", 32'(q_h), 32'h1234);

      // ---- 5: load coinciding with a count tick; zero together with load ----
      enable = 1'b1;
      data = 16'h0777;
      align_to_tick("t5_ld");
      load = 1'b1;
      wait_clk(7);
      check("t5_ld_tick_bcd", 32'(q_b), 32'h0777);
      check("t5_ld_tick_hex", 32'(q_h), 32'h0777);
      wait_clk(2);
      check("t5_ld_hold", 32'(q_b), 32'h0777);
      load = 1'b0;
      wait_clk(10);
      check("t5_next_step", 32'(q_b), 32'h0778);
      align_to_tick("t5_zero");
      load = 1'b1;
      zero = 1'b1;
      wait_clk(7);
      check("t5_zero_bcd", 32'(q_b),  32'h0000);
      check("t5_zero_hex", 32'(q_h),  32'h0000);
      check("t5_zero_tc",  32'(tc_b), 32'h0);
      load = 1'b0;
      zero = 1'b0;
      wait_clk(12);

      // ---- 6: asynchronous clear mid-count ----
      enable = 1'b0;
      data = 16'h0042;
      press(0);
      check("t6_load", 32'(q_b), 32'h0042);
      enable = 1'b1;
      wait_clk(3);
      @(posedge clk);
      #3;
      clr = 1'b0;
      #1;
      check("t6_q",    32'(q_b),    32'h0000);
      check("t6_scan", 32'(scan_b), 32'b1110);
      check("t6_seg",  32'(seg_b),  32'h40);
      check("t6_up",   32'(up_b),   32'h1);
      check("t6_q_hex", 32'(q_h),   32'h0000);
      wait_clk(2);
      clr = 1'b1;
      wait_clk(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
